// File: rtl/eth_stream_pkg.sv
// eth_stream_pkg: shared types for the stream packet buffer.
//   in_state_t    : input-side packet state (IDLE waits for metadata, PKT inside a packet)
//   entry_flags_t : per-beat sideband stored next to tdata in each FIFO entry
//   max_pkt()     : largest packet in beats (metadata + data beats + strobe beat)
package eth_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } in_state_t;

  typedef struct packed {
    logic tuser;
    logic tlast;
  } entry_flags_t;

  function automatic int max_pkt(input int burst_size);
    return burst_size + 2;
  endfunction

endpackage

// File: rtl/stream_pkt_fifo.sv
// stream_pkt_fifo: synchronous FIFO with packet-start mark/rollback and a count of
// committed (tlast-written) packets.
//   clk, reset : clock, asynchronous active-high reset
//   wr_en      : write wr_data (ignored when full)
//   mark       : remember the current write pointer as the start of a packet
//   rollback   : restore the write pointer to the marked packet start
//   rd_en      : pop the head entry presented on rd_data
//   rd_avail   : head entry may be read (store-forward: only once a whole packet is in)
//   free       : number of unused entries
module stream_pkt_fifo #(
  parameter int WIDTH     = 130,
  parameter int DEPTH     = 16,
  parameter int LAST_BIT  = 128,
  parameter bit STORE_FWD = 1'b0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             mark,
  input  logic             rollback,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_avail,
  output logic [AW:0]      free
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, mark_ptr, pkt_cnt;
  logic             empty, full, wr_ok, rd_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign free     = (AW+1)'(DEPTH) - (wr_ptr - rd_ptr);
  assign wr_ok    = wr_en & ~full;
  assign rd_ok    = rd_en & ~empty;
  assign rd_data  = mem[rd_ptr[AW-1:0]];
  // The head packet is always the oldest, so any committed packet means the head is whole.
  assign rd_avail = ~empty & (~STORE_FWD | (pkt_cnt != '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mark_ptr <= '0;
      pkt_cnt  <= '0;
    end else begin
      if (rollback)   wr_ptr <= mark_ptr;
      else if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (mark)       mark_ptr <= wr_ptr;
      if (rd_ok)      rd_ptr <= rd_ptr + (AW+1)'(1);
      case ({wr_ok & wr_data[LAST_BIT], rd_ok & rd_data[LAST_BIT]})
        2'b10:   pkt_cnt <= pkt_cnt + (AW+1)'(1);
        2'b01:   pkt_cnt <= pkt_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/stream_packet_buffer.sv
// stream_packet_buffer: buffers the upstream beat stream (metadata, data beats, strobe
// beat) in a FIFO and drives an AXI4-Stream master with a registered output stage.
// Packets aborted mid-burst are terminated (cut-through) or discarded (store-forward).
// Build option: define STORE_AND_FORWARD_EN for store-and-forward; default is cut-through.
//   clk, reset                      : clock, asynchronous active-high reset
//   s_valid/s_ready/s_data          : upstream beat handshake and payload
//   s_in_progress                   : upstream is past its metadata beat
//   s_last                          : current beat is the strobe (final) beat
//   m_axis_tdata/tvalid/tready      : downstream stream
//   m_axis_tlast, m_axis_tuser      : end of packet, aborted-packet flag on the tlast beat
//   pkt_count, drop_count           : saturating completed / aborted packet counters
module stream_packet_buffer
  import eth_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int BURST_SIZE = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_in_progress,
  input  logic                  s_last,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  localparam int MAX_PKT = max_pkt(BURST_SIZE);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int BW      = $clog2(MAX_PKT + 1);
  localparam int EW      = DATA_WIDTH + 2;
`ifdef STORE_AND_FORWARD_EN
  localparam bit STORE_FWD = 1'b1;
`else
  localparam bit STORE_FWD = 1'b0;
`endif

  typedef struct packed {
    entry_flags_t            flags;
    logic [DATA_WIDTH-1:0]   tdata;
  } fifo_entry_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  in_state_t             state, state_nxt;
  logic [BW-1:0]         beat_cnt;
  logic                  run, term_pending, hs, overflow, abort, rollback;
  logic                  wr_en, mark, rd_avail, load;
  logic [AW:0]           free;
  fifo_entry_t           wr_entry, rd_entry;
  logic                  vld_p1;
  entry_flags_t          flags_p1;
  logic [DATA_WIDTH-1:0] tdata_p1;

  // ---- input stage: admission, packet state, abort detection ----
  // A packet is admitted only with room for MAX_PKT beats plus one terminator, so once
  // inside a packet ready stays high until the packet ends or overruns MAX_PKT.
  assign overflow = (state == PKT) && (beat_cnt == BW'(MAX_PKT));
  assign s_ready  = run & ~term_pending &
                    ((state == PKT) ? ~overflow : (free >= (AW+1)'(MAX_PKT + 1)));
  assign hs       = s_valid & s_ready;
  assign abort    = (state == PKT) & ((~s_in_progress & ~hs) | overflow);
  assign mark     = hs & (state == IDLE);
  assign wr_en    = hs | term_pending;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = PKT;
      PKT:     if (abort || (hs && s_last)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_entry.flags.tuser = 1'b0;
    wr_entry.flags.tlast = (state == PKT) & s_last;
    wr_entry.tdata       = s_data;
    if (term_pending) begin
      wr_entry.flags.tuser = 1'b1;
      wr_entry.flags.tlast = 1'b1;
      wr_entry.tdata       = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      run        <= 1'b0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
      if (state_nxt == IDLE) beat_cnt <= '0;
      else if (hs)           beat_cnt <= beat_cnt + BW'(1);
      if (hs && (state == PKT) && s_last) pkt_count <= sat_inc(pkt_count);
      if (abort)                          drop_count <= sat_inc(drop_count);
    end
  end

`ifdef STORE_AND_FORWARD_EN
  // The partial packet is erased by restoring the write pointer; nothing reaches the output.
  assign rollback     = abort;
  assign term_pending = 1'b0;
`else
  // The terminator is written one cycle after the abort, into the reserved slot.
  assign rollback = 1'b0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) term_pending <= 1'b0;
    else       term_pending <= abort;
  end
`endif

  // ---- buffer stage ----
  stream_pkt_fifo #(
    .WIDTH     (EW),
    .DEPTH     (FIFO_DEPTH),
    .LAST_BIT  (DATA_WIDTH),
    .STORE_FWD (STORE_FWD)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_entry),
    .mark     (mark),
    .rollback (rollback),
    .rd_en    (load),
    .rd_data  (rd_entry),
    .rd_avail (rd_avail),
    .free     (free)
  );

  // ---- output stage p1: registered AXI4-Stream master ----
  assign load = rd_avail & (~vld_p1 | m_axis_tready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      flags_p1 <= '0;
    end else if (load) begin
      vld_p1   <= 1'b1;
      flags_p1 <= rd_entry.flags;
    end else if (m_axis_tready) begin
      vld_p1   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) tdata_p1 <= rd_entry.tdata;
  end

  assign m_axis_tvalid = vld_p1;
  assign m_axis_tdata  = tdata_p1;
  assign m_axis_tlast  = flags_p1.tlast;
  assign m_axis_tuser  = flags_p1.tuser;

endmodule

// File: tb/tb_stream_packet_buffer.sv
// Scoreboard bench for stream_packet_buffer: accepted beats push expected output entries
// {tuser, tlast, tdata}; a monitor pops and compares on every output handshake and checks
// that the output holds while stalled.
module tb_stream_packet_buffer;

  localparam int DW    = 128;
  localparam int CW    = 4;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid, s_ready, s_in_progress, s_last;
  logic [DW-1:0] s_data;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic [CW-1:0] pkt_count, drop_count;

  int            n_cmp  = 0;
  int            n_fail = 0;
  int            tmode  = 0;   // 0: tready low, 1: tready high, 2: toggle
  logic [DW+1:0] sb[$];
`ifdef STORE_AND_FORWARD_EN
  logic [DW+1:0] pend[$];
`endif

  stream_packet_buffer #(
    .DATA_WIDTH (DW),
    .BURST_SIZE (BURST),
    .FIFO_DEPTH (16),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_in_progress (s_in_progress),
    .s_last        (s_last),
    .s_data        (s_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .pkt_count     (pkt_count),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW+1:0] act, input logic [DW+1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [DW+1:0] e);
`ifdef STORE_AND_FORWARD_EN
    pend.push_back(e);
`else
    sb.push_back(e);
`endif
  endtask

  // tready pattern generator
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (tmode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = ~m_axis_tready;
      endcase
    end
  end

  // Output monitor
  initial begin
    logic          stall;
    logic [DW+1:0] held, got;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = 1'b0;
      end else begin
        got = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
        if (stall) begin
          check("stall_valid", {{(DW+1){1'b0}}, m_axis_tvalid}, {{(DW+1){1'b0}}, 1'b1});
          check("stall_hold", got, held);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_beat: got %h expected none", got);
          end else begin
            check("out_beat", got, sb.pop_front());
          end
        end
        stall = m_axis_tvalid & ~m_axis_tready;
        held  = got;
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic inprog,
                           output bit ok);
    s_valid = 1'b1; s_data = d; s_last = last; s_in_progress = inprog; ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL s_ready_timeout: got no handshake expected one for %h", d);
    end
  endtask

  // abort_after < 0: complete packet; otherwise abort after that many data beats.
  task automatic send_pkt(input logic [DW-1:0] base, input int abort_after);
    bit            ok;
    logic [DW-1:0] d;
    send_beat(base, 1'b0, 1'b0, ok);
    if (ok) exp_push({2'b00, base});
    for (int i = 0; i <= BURST; i++) begin
      if (i == abort_after) begin
        s_in_progress = 1'b0;
`ifdef STORE_AND_FORWARD_EN
        pend.delete();
`else
        sb.push_back({2'b11, {DW{1'b0}}});
`endif
        repeat (2) @(posedge clk);
        #1;
        return;
      end
      d = base + DW'(i + 1);
      send_beat(d, (i == BURST), 1'b1, ok);
      if (ok) exp_push({1'b0, (i == BURST), d});
    end
    s_in_progress = 1'b0;
`ifdef STORE_AND_FORWARD_EN
    while (pend.size() > 0) sb.push_back(pend.pop_front());
`endif
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((sb.size() != 0 || m_axis_tvalid) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drained"}, (sb.size() == 0 && !m_axis_tvalid), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    reset = 1'b1; s_valid = 1'b0; s_in_progress = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_sready", s_ready, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tuser", m_axis_tuser, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_drop_count", drop_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: single packet, tready high
    tmode = 1;
    send_pkt(DW'('h100), -1);
    drain("t1");
    check("t1_pkt_count", pkt_count, 1);
    check("t1_drop_count", drop_count, 0);

    // 2: tready low, three packets; only two fit
    tmode = 0;
    fork
      for (int p = 0; p < 3; p++) send_pkt(DW'('h200 + p * 'h10), -1);
      begin
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("t2_sready_blocked", s_ready, 0);
        check("t2_pkt_admitted", pkt_count, 3);
        check("t2_beats_queued", sb.size(), 12);
        tmode = 1;
      end
    join
    drain("t2");
    check("t2_pkt_count", pkt_count, 4);

    // 3: abort after D1
    send_pkt(DW'('h300), 2);
    drain("t3");
    check("t3_drop_count", drop_count, 1);
    check("t3_pkt_count", pkt_count, 4);
    @(negedge clk);
    check("t3_sready_idle", s_ready, 1);
    @(posedge clk); #1;

    // 4: tready toggling over ten packets
    tmode = 2;
    for (int p = 0; p < 10; p++) send_pkt(DW'('h400 + p * 'h10), -1);
    drain("t4");
    check("t4_pkt_count", pkt_count, 14);

    // 5: reset during D2
    tmode = 1;
    send_beat(DW'('h500), 1'b0, 1'b0, ok);
    if (ok) exp_push({2'b00, DW'('h500)});
    send_beat(DW'('h501), 1'b0, 1'b1, ok);
    if (ok) exp_push({2'b00, DW'('h501)});
    send_beat(DW'('h502), 1'b0, 1'b1, ok);
    if (ok) exp_push({2'b00, DW'('h502)});
    s_valid = 1'b1; s_data = DW'('h503); s_in_progress = 1'b1;
    reset = 1'b1;
    sb.delete();
`ifdef STORE_AND_FORWARD_EN
    pend.delete();
`endif
    @(negedge clk);
    check("t5_tvalid", m_axis_tvalid, 0);
    check("t5_sready", s_ready, 0);
    check("t5_pkt_count", pkt_count, 0);
    check("t5_drop_count", drop_count, 0);
    @(posedge clk); #1;
    s_valid = 1'b0; s_in_progress = 1'b0;
    reset = 1'b0;
    send_pkt(DW'('h600), -1);
    drain("t5");
    check("t5_pkt_after", pkt_count, 1);
    check("t5_drop_after", drop_count, 0);

    // 6: sixteen aborts saturate a 4-bit drop counter
    for (int k = 0; k < 16; k++) send_pkt(DW'('h700 + k * 'h10), 0);
    drain("t6");
    check("t6_drop_sat", drop_count, 15);
    check("t6_pkt_count", pkt_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
